cordic_alu_seq: RTL and testbench



---
 rtl/cordic_alu_seq.sv | 172 +++++++++++++++++
 tb/tb_cordic_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_alu_seq.sv
// Iterative CORDIC rotation-mode sequencer that borrows the shared 32-bit ALU.
// Each iteration issues two arithmetic shifts, then add/sub micro-ops on x, y and z.
module cordic_alu_seq #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    typedef enum logic [2:0] {
        st_idle = 3'd0,
        st_shx  = 3'd1,
        st_shy  = 3'd2,
        st_upx  = 3'd3,
        st_upy  = 3'd4,
        st_upz  = 3'd5,
        st_done = 3'd6
    } state_t;

    localparam logic [3:0] op_add  = 4'b0000;
    localparam logic [3:0] op_sub  = 4'b0001;
    localparam logic [3:0] op_sra  = 4'b1000;
    localparam logic [3:0] op_idle = 4'b1111;
    localparam logic [4:0] last_idx = 5'(ITER - 1);

    // Beyond index 9, atan(2^-i) rounds to exactly 2^(30-i) in Q2.30.
    function automatic logic [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'h3243F6A9;
            5'd1:    atan_rom = 32'h1DAC6705;
            5'd2:    atan_rom = 32'h0FADBAFD;
            5'd3:    atan_rom = 32'h07F56EA7;
            5'd4:    atan_rom = 32'h03FEAB77;
            5'd5:    atan_rom = 32'h01FFD55C;
            5'd6:    atan_rom = 32'h00FFFAAB;
            5'd7:    atan_rom = 32'h007FFF55;
            5'd8:    atan_rom = 32'h003FFFEB;
            5'd9:    atan_rom = 32'h001FFFFD;
            default: atan_rom = 32'd1 << (5'd30 - idx);
        endcase
    endfunction

    state_t      state_r;
    state_t      next_s;
    logic [4:0]  i_r;
    logic [31:0] x_r;
    logic [31:0] y_r;
    logic [31:0] z_r;
    logic [31:0] tx_r;
    logic [31:0] ty_r;
    logic        busy_r;
    logic        done_r;
    logic        dir_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [3:0]  alu_ctrl_s;

    // z only changes at the end of UPZ, so the direction is stable within an iteration
    assign dir_s = ~z_r[31];

    // Next-state decode and ALU micro-op selection
    always_comb begin
        next_s     = state_r;
        alu_a_s    = 32'd0;
        alu_b_s    = 32'd0;
        alu_ctrl_s = op_idle;
        case (state_r)
            st_idle: begin
                if (start) next_s = st_shx;
                else       next_s = st_idle;
            end
            st_shx: begin
                alu_a_s    = x_r;
                alu_b_s    = {27'd0, i_r};
                alu_ctrl_s = op_sra;
                next_s     = st_shy;
            end
            st_shy: begin
                alu_a_s    = y_r;
                alu_b_s    = {27'd0, i_r};
                alu_ctrl_s = op_sra;
                next_s     = st_upx;
            end
            st_upx: begin
                alu_a_s    = x_r;
                alu_b_s    = ty_r;
                alu_ctrl_s = dir_s ? op_sub : op_add;
                next_s     = st_upy;
            end
            st_upy: begin
                alu_a_s    = y_r;
                alu_b_s    = tx_r;
                alu_ctrl_s = dir_s ? op_add : op_sub;
                next_s     = st_upz;
            end
            st_upz: begin
                alu_a_s    = z_r;
                alu_b_s    = atan_rom(i_r);
                alu_ctrl_s = dir_s ? op_sub : op_add;
                if (i_r == last_idx) next_s = st_done;
                else                 next_s = st_shx;
            end
            st_done: begin
                if (start) next_s = st_shx;
                else       next_s = st_idle;
            end
            default: next_s = st_idle;
        endcase
    end

    // State, datapath registers and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= st_idle;
            i_r     <= 5'd0;
            x_r     <= 32'd0;
            y_r     <= 32'd0;
            z_r     <= 32'd0;
            tx_r    <= 32'd0;
            ty_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != st_idle) && (next_s != st_done);
            done_r  <= (next_s == st_done);
            case (state_r)
                st_idle, st_done: begin
                    if (start) begin
                        x_r <= x_in;
                        y_r <= y_in;
                        z_r <= z_in;
                        i_r <= 5'd0;
                    end
                end
                st_shx: tx_r <= alu_result;
                st_shy: ty_r <= alu_result;
                st_upx: x_r  <= alu_result;
                st_upy: y_r  <= alu_result;
                st_upz: begin
                    z_r <= alu_result;
                    if (i_r != last_idx) i_r <= i_r + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign x_out    = x_r;
    assign y_out    = y_r;
    assign z_out    = z_r;
    assign alu_a    = alu_a_s;
    assign alu_b    = alu_b_s;
    assign alu_ctrl = alu_ctrl_s;

endmodule

// File: tb/tb_cordic_alu_seq.sv
// Directed + randomized bench for cordic_alu_seq: an ITER=16 and an ITER=1 instance,
// each served by a behavioural ALU, checked against a plain-arithmetic CORDIC model.
module tb_cordic_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start16, start1;
    logic [31:0] x16_in, y16_in, z16_in, x1_in, y1_in, z1_in;
    logic        busy16, done16, busy1, done1;
    logic [31:0] x16_out, y16_out, z16_out, x1_out, y1_out, z1_out;
    logic [31:0] a16, b16, r16, a1, b1, r1;
    logic [3:0]  ctrl16, ctrl1;

    int n_cmp = 0;
    int n_err = 0;
    int atan_tab[32];
    int lat;
    logic [31:0] xr, yr, zr;
    logic [31:0] rx, ry, rz;
    real kn, phi, ex, ey;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        case (c)
            4'b0000: alu_model = a + b;
            4'b0001: alu_model = a - b;
            4'b1000: alu_model = 32'($signed(a) >>> b[4:0]);
            default: alu_model = 32'd0;
        endcase
    endfunction

    assign r16 = alu_model(a16, b16, ctrl16);
    assign r1  = alu_model(a1, b1, ctrl1);

    cordic_alu_seq #(.ITER(16)) u16 (
        .clk(clk), .rst(rst), .start(start16),
        .x_in(x16_in), .y_in(y16_in), .z_in(z16_in),
        .busy(busy16), .done(done16),
        .x_out(x16_out), .y_out(y16_out), .z_out(z16_out),
        .alu_a(a16), .alu_b(b16), .alu_ctrl(ctrl16), .alu_result(r16)
    );

    cordic_alu_seq #(.ITER(1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .x_in(x1_in), .y_in(y1_in), .z_in(z1_in),
        .busy(busy1), .done(done1),
        .x_out(x1_out), .y_out(y1_out), .z_out(z1_out),
        .alu_a(a1), .alu_b(b1), .alu_ctrl(ctrl1), .alu_result(r1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input real exp, input int tol);
        real diff;
        diff = $itor($signed(obs)) - exp;
        n_cmp++;
        assert (diff <= $itor(tol) && diff >= -$itor(tol)) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0.1f +/- %0d", tag, $signed(obs), exp, tol);
        end
    endtask

    // Rotation-mode CORDIC straight from the algorithm, in wrapping 32-bit arithmetic
    task automatic cordic_ref(input int n, input logic [31:0] x0, input logic [31:0] y0,
                              input logic [31:0] z0, output logic [31:0] xo,
                              output logic [31:0] yo, output logic [31:0] zo);
        int x, y, z, tx, ty;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < n; k++) begin
            tx = x >>> k;
            ty = y >>> k;
            if (z >= 0) begin
                x = x - ty; y = y + tx; z = z - atan_tab[k];
            end else begin
                x = x + ty; y = y - tx; z = z + atan_tab[k];
            end
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic go16(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        x16_in = x; y16_in = y; z16_in = z; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic wait_done16(input int cnt0, output int l);
        int k;
        k = cnt0;
        l = -1;
        while (l < 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (done16) l = k;
        end
    endtask

    task automatic wait_done1(input int cnt0, output int l);
        int k;
        k = cnt0;
        l = -1;
        while (l < 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
            if (done1) l = k;
        end
    endtask

    // Samples the five micro-ops of iteration 0; ends four edges after acceptance
    task automatic trace16(input bit neg);
        chk("tr_shx_ctrl", {28'd0, ctrl16}, 32'h8);
        chk("tr_shx_b", b16, 32'd0);
        @(posedge clk); #1;
        chk("tr_shy_ctrl", {28'd0, ctrl16}, 32'h8);
        @(posedge clk); #1;
        chk("tr_upx_ctrl", {28'd0, ctrl16}, neg ? 32'h0 : 32'h1);
        @(posedge clk); #1;
        chk("tr_upy_ctrl", {28'd0, ctrl16}, neg ? 32'h1 : 32'h0);
        @(posedge clk); #1;
        chk("tr_upz_ctrl", {28'd0, ctrl16}, neg ? 32'h0 : 32'h1);
        chk("tr_upz_b", b16, 32'h3243F6A9);
    endtask

    initial begin
        for (int k = 0; k < 32; k++)
            atan_tab[k] = (k < 31) ? $rtoi($atan(2.0 ** (-1.0 * k)) * 1073741824.0 + 0.5) : 0;
        kn = 1.0;
        for (int k = 0; k < 16; k++) kn = kn * $sqrt(1.0 + 2.0 ** (-2.0 * k));

        rst = 1'b1; start16 = 1'b0; start1 = 1'b0;
        x16_in = 32'd0; y16_in = 32'd0; z16_in = 32'd0;
        x1_in = 32'd0; y1_in = 32'd0; z1_in = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", {31'd0, busy16}, 32'd0);
        chk("rst_done", {31'd0, done16}, 32'd0);
        chk("rst_x", x16_out, 32'd0);
        chk("rst_z", z16_out, 32'd0);
        chk("rst_ctrl", {28'd0, ctrl16}, 32'hF);
        chk("rst_alu_a", a16, 32'd0);

        // Rotate by pi/4 from the pre-scaled unit vector
        go16(32'h26DD3B6A, 32'd0, 32'h3243F6A9);
        chk("pi4_busy", {31'd0, busy16}, 32'd1);
        chk("pi4_alu_a", a16, 32'h26DD3B6A);
        trace16(1'b0);
        wait_done16(4, lat);
        chk("pi4_latency", lat, 32'd80);
        chk("pi4_busy_fall", {31'd0, busy16}, 32'd0);
        cordic_ref(16, 32'h26DD3B6A, 32'd0, 32'h3243F6A9, rx, ry, rz);
        chk("pi4_x", x16_out, rx);
        chk("pi4_y", y16_out, ry);
        chk("pi4_z", z16_out, rz);
        phi = ($itor(32'sh3243F6A9) - $itor($signed(z16_out))) / 1073741824.0;
        chk_tol("pi4_x_geom", x16_out, 652032874.0 * kn * $cos(phi), 64);
        chk_tol("pi4_y_geom", y16_out, 652032874.0 * kn * $sin(phi), 64);
        chk_tol("pi4_z_small", z16_out, 0.0, 65535);
        @(posedge clk); #1;
        chk("pi4_done_pulse", {31'd0, done16}, 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("pi4_x_held", x16_out, rx);

        // Zero angle
        go16(32'h26DD3B6A, 32'd0, 32'd0);
        wait_done16(0, lat);
        chk("zero_latency", lat, 32'd80);
        cordic_ref(16, 32'h26DD3B6A, 32'd0, 32'd0, rx, ry, rz);
        chk("zero_x", x16_out, rx);
        chk("zero_y", y16_out, ry);
        phi = -$itor($signed(z16_out)) / 1073741824.0;
        chk_tol("zero_x_geom", x16_out, 652032874.0 * kn * $cos(phi), 64);
        chk_tol("zero_y_small", y16_out, 0.0, 65535);

        // Negative angle flips the add/sub micro-ops
        go16(32'h20000000, 32'h10000000, 32'hF0000000);
        trace16(1'b1);
        wait_done16(4, lat);
        chk("neg_latency", lat, 32'd80);
        cordic_ref(16, 32'h20000000, 32'h10000000, 32'hF0000000, rx, ry, rz);
        chk("neg_x", x16_out, rx);
        chk("neg_y", y16_out, ry);
        chk("neg_z", z16_out, rz);

        // Random operands, exact model comparison
        for (int t = 0; t < 4; t++) begin
            xr = $urandom; yr = $urandom; zr = $urandom;
            go16(xr, yr, zr);
            wait_done16(0, lat);
            cordic_ref(16, xr, yr, zr, rx, ry, rz);
            chk("rnd_latency", lat, 32'd80);
            chk("rnd_x", x16_out, rx);
            chk("rnd_y", y16_out, ry);
            chk("rnd_z", z16_out, rz);
        end

        // Reset mid-iteration aborts immediately and cleanly
        go16(32'h12345678, 32'h0FEDCBA9, 32'h1F000000);
        repeat (30) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("abort_busy", {31'd0, busy16}, 32'd0);
        chk("abort_done", {31'd0, done16}, 32'd0);
        chk("abort_x", x16_out, 32'd0);
        chk("abort_y", y16_out, 32'd0);
        chk("abort_z", z16_out, 32'd0);
        chk("abort_ctrl", {28'd0, ctrl16}, 32'hF);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (60) @(posedge clk); #1;
        chk("abort_no_done", {31'd0, done16}, 32'd0);
        xr = $urandom; yr = $urandom; zr = $urandom;
        go16(xr, yr, zr);
        wait_done16(0, lat);
        cordic_ref(16, xr, yr, zr, rx, ry, rz);
        chk("post_rst_latency", lat, 32'd80);
        chk("post_rst_x", x16_out, rx);
        chk("post_rst_y", y16_out, ry);

        // ITER=1: latency 5, start during busy ignored
        @(negedge clk);
        x1_in = 32'h30000000; y1_in = 32'h08000000; z1_in = 32'h01000000; start1 = 1'b1;
        @(posedge clk); #1;
        x1_in = 32'h7FFFFFFF; y1_in = 32'h55555555; z1_in = 32'h80000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done1(2, lat);
        chk("i1_latency", lat, 32'd5);
        cordic_ref(1, 32'h30000000, 32'h08000000, 32'h01000000, rx, ry, rz);
        chk("i1_x", x1_out, rx);
        chk("i1_y", y1_out, ry);
        chk("i1_z", z1_out, rz);
        @(posedge clk); #1;
        chk("i1_done_pulse", {31'd0, done1}, 32'd0);

        // Held start: back-to-back runs with no idle gap
        @(negedge clk);
        x1_in = 32'hE0000000; y1_in = 32'h20000000; z1_in = 32'hF8000000; start1 = 1'b1;
        @(posedge clk); #1;
        chk("hold_busy0", {31'd0, busy1}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk("hold_active", {31'd0, busy1 | done1}, 32'd1);
            chk("hold_done", {31'd0, done1}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
        end
        start1 = 1'b0;
        wait_done1(0, lat);
        chk("hold_last_latency", lat, 32'd5);
        cordic_ref(1, 32'hE0000000, 32'h20000000, 32'hF8000000, rx, ry, rz);
        chk("hold_x", x1_out, rx);
        chk("hold_y", y1_out, ry);
        chk("hold_z", z1_out, rz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
